// File: rtl/aes256_sched_if.sv
// rtl/aes256_sched_if.sv - request, key, device and response signals of aes256_sched
// err_spurious/err_count are present only when AES256_SCHED_ERRCNT_EN is defined.
interface aes256_sched_if;
  logic         key_valid;
  logic [255:0] key_data;
  logic         key_ready;
  logic         ch0_valid, ch1_valid;
  logic         ch0_dec, ch1_dec;
  logic [127:0] ch0_data, ch1_data;
  logic         ch0_ready, ch1_ready;
  logic [127:0] dev_inp;
  logic         dev_ctrl_dataIn;
  logic [1:0]   dev_mod_en;
  logic [127:0] dev_outp;
  logic         dev_ctrl_dataOut;
  logic         rsp_valid;
  logic         rsp_ch;
  logic [127:0] rsp_data;
  logic         key_loaded;
`ifdef AES256_SCHED_ERRCNT_EN
  logic         err_spurious;
  logic [7:0]   err_count;
`endif

  modport slave (
    input  key_valid, key_data, ch0_valid, ch1_valid, ch0_dec, ch1_dec,
           ch0_data, ch1_data, dev_outp, dev_ctrl_dataOut,
`ifdef AES256_SCHED_ERRCNT_EN
    output err_spurious, err_count,
`endif
    output key_ready, ch0_ready, ch1_ready, dev_inp, dev_ctrl_dataIn, dev_mod_en,
           rsp_valid, rsp_ch, rsp_data, key_loaded
  );

  modport master (
    output key_valid, key_data, ch0_valid, ch1_valid, ch0_dec, ch1_dec,
           ch0_data, ch1_data, dev_outp, dev_ctrl_dataOut,
`ifdef AES256_SCHED_ERRCNT_EN
    input  err_spurious, err_count,
`endif
    input  key_ready, ch0_ready, ch1_ready, dev_inp, dev_ctrl_dataIn, dev_mod_en,
           rsp_valid, rsp_ch, rsp_data, key_loaded
  );
endinterface

// File: rtl/aes256_sched.sv
// rtl/aes256_sched.sv - two-channel scheduler and key loader in front of an AES-256 device
// Define AES256_SCHED_ERRCNT_EN to add err_spurious/err_count for unexpected device results.
module aes256_sched #(
  parameter int FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          resetn,
  aes256_sched_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, KEY_LO, KEY_HI} state_t;
  state_t state, state_nxt;

  logic [PW:0]           count;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [FIFO_DEPTH-1:0] tag_mem;
  logic                  rr_prio;
  logic                  key_loaded;
  logic [127:0]          key_hi;
  logic [127:0]          dev_inp_q;
  logic [1:0]            dev_mod_q;
  logic                  dev_in_q;
  logic                  rsp_valid_q, rsp_ch_q;
  logic [127:0]          rsp_data_q;
  logic                  gnt0, gnt1, key_rdy, set_loaded, ch_xfer, pop;

  // Readies come only from state, count, key_loaded, rr_prio and the valids.
  always_comb begin
    state_nxt  = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    key_rdy    = 1'b0;
    set_loaded = 1'b0;
    case (state)
      IDLE: begin
        if (bus.key_valid) begin
          state_nxt = DRAIN;
        end else if (key_loaded && count < FULL) begin
          if (bus.ch0_valid && (!bus.ch1_valid || !rr_prio)) gnt0 = 1'b1;
          else if (bus.ch1_valid)                           gnt1 = 1'b1;
        end
      end
      DRAIN: begin
        if (!bus.key_valid) begin
          state_nxt = IDLE;
        end else if (count == '0) begin
          key_rdy   = 1'b1;
          state_nxt = KEY_LO;
        end
      end
      KEY_LO: state_nxt = KEY_HI;
      KEY_HI: begin
        set_loaded = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ch_xfer = gnt0 | gnt1;
  assign pop     = bus.dev_ctrl_dataOut && (count != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_mem     <= '0;
      rr_prio     <= 1'b0;
      key_loaded  <= 1'b0;
      key_hi      <= '0;
      dev_inp_q   <= '0;
      dev_mod_q   <= '0;
      dev_in_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      dev_in_q <= ch_xfer | key_rdy | (state == KEY_LO);
      if (ch_xfer) begin
        dev_inp_q <= gnt1 ? bus.ch1_data : bus.ch0_data;
        dev_mod_q <= {1'b0, gnt1 ? bus.ch1_dec : bus.ch0_dec};
        rr_prio   <= gnt0;
        tag_mem[wr_ptr] <= gnt1;
        wr_ptr    <= wr_ptr + 1'b1;
      end else if (key_rdy) begin
        dev_inp_q <= bus.key_data[127:0];
        dev_mod_q <= 2'b10;
        key_hi    <= bus.key_data[255:128];
      end else if (state == KEY_LO) begin
        dev_inp_q <= key_hi;
        dev_mod_q <= 2'b10;
      end
      if (set_loaded) key_loaded <= 1'b1;

      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({ch_xfer, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      rsp_valid_q <= pop;
      if (pop) begin
        rsp_ch_q   <= tag_mem[rd_ptr];
        rsp_data_q <= bus.dev_outp;
      end
    end
  end

  assign bus.ch0_ready       = gnt0;
  assign bus.ch1_ready       = gnt1;
  assign bus.key_ready       = key_rdy;
  assign bus.dev_inp         = dev_inp_q;
  assign bus.dev_mod_en      = dev_mod_q;
  assign bus.dev_ctrl_dataIn = dev_in_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_ch          = rsp_ch_q;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.key_loaded      = key_loaded;

`ifdef AES256_SCHED_ERRCNT_EN
  logic       spurious;
  logic       err_sp_q;
  logic [7:0] err_cnt_q;

  assign spurious = bus.dev_ctrl_dataOut && (count == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_sp_q  <= 1'b0;
      err_cnt_q <= '0;
    end else if (spurious) begin
      err_sp_q <= 1'b1;
      if (err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.err_spurious = err_sp_q;
  assign bus.err_count    = err_cnt_q;
`endif
endmodule

// File: doc/aes256_sched.md
AES256_SCHED -- requirements
Module: aes256_sched

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the maximum number of operations outstanding in AES256_device; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- key_valid  in  1  a key load is requested.
- key_data  in  256  AES-256 key.
- key_ready  out  1  the key is accepted this cycle.
- ch0_valid, ch1_valid  in  1  requester N has an operation pending.
- ch0_dec, ch1_dec  in  1  operation type: 0 = encrypt, 1 = decrypt.
- ch0_data, ch1_data  in  128  input block.
- ch0_ready, ch1_ready  out  1  requester N is granted this cycle.
- dev_inp  out  128  drives AES256_device inp_device.
- dev_ctrl_dataIn  out  1  drives ctrl_dataIn.
- dev_mod_en  out  2  drives mod_en: 00 = encrypt, 01 = decrypt, 10 = key load.
- dev_outp  in  128  from outp_device.
- dev_ctrl_dataOut  in  1  from ctrl_dataOut.
- rsp_valid  out  1  response strobe, one cycle per result.
- rsp_ch  out  1  requester that owns the response.
- rsp_data  out  128  result block.
- key_loaded  out  1  a complete key has been written to the device.

Function
REQ-003 An operation transfers when chN_valid and chN_ready are both high; a key transfers when key_valid and key_ready are both high.
REQ-004 At most one of ch0_ready, ch1_ready and key_ready SHALL be high in any cycle, and each ready SHALL depend only on registered state and the valid inputs.
REQ-005 The block SHALL use a state machine with states IDLE, DRAIN, KEY_LO and KEY_HI.
REQ-006 In IDLE with key_valid high, the block SHALL go to DRAIN. Key requests take priority over channel requests, and no channel grant is given from that cycle on.
REQ-007 In DRAIN, the block SHALL wait until the outstanding count is 0. It SHALL then assert key_ready for one cycle, latch key_data and go to KEY_LO.
REQ-008 In KEY_LO, the block SHALL drive dev_ctrl_dataIn=1, dev_mod_en=10 and dev_inp=key[127:0], then go to KEY_HI.
REQ-009 In KEY_HI, the block SHALL drive dev_ctrl_dataIn=1, dev_mod_en=10 and dev_inp=key[255:128], set key_loaded, then go to IDLE.
REQ-010 In IDLE with key_valid low, key_loaded=1 and outstanding count < FIFO_DEPTH, the block SHALL grant one valid channel using round-robin. The channel not granted last time wins when both are valid. The pointer SHALL reset to favour ch0.
REQ-011 When key_loaded=0, the block SHALL not give any channel grant.
REQ-012 On a channel transfer in cycle T, the block SHALL drive dev_ctrl_dataIn=1 in cycle T+1 for exactly one cycle, with dev_inp=chN_data and dev_mod_en={1'b0,chN_dec}. It SHALL also push N into the tag FIFO.
REQ-013 The block SHALL issue at most one operation or key half per cycle, and back-to-back grants SHALL be allowed.
REQ-014 When dev_ctrl_dataIn=0, dev_inp and dev_mod_en SHALL hold their previous values.
REQ-015 When dev_ctrl_dataOut=1 and the tag FIFO is not empty, the block SHALL pop the tag. In the next cycle it SHALL drive rsp_valid=1, rsp_ch=tag and rsp_data=dev_outp as registered. Latency is one cycle.
REQ-016 The block SHALL return responses in issue order and SHALL not accept backpressure on rsp.
REQ-017 The outstanding count SHALL equal the tag FIFO occupancy. With simultaneous push and pop the count SHALL be unchanged, and the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 When the count equals FIFO_DEPTH, the block SHALL not give any channel grant, even if a pop occurs in the same cycle.
REQ-019 When dev_ctrl_dataOut=1 and the FIFO is empty, the block SHALL treat it as spurious: no rsp_valid and no pointer change.

Reset
REQ-020 While resetn=0, the block SHALL drive all outputs to 0, empty the FIFO, clear key_loaded, set the state to IDLE and reset the round-robin pointer to ch0.
REQ-021 Reset asserted during an operation SHALL abandon any partial key load and all outstanding tags. After release, key_loaded=0 until a new key load completes.

Configuration
REQ-022 When macro AES256_SCHED_ERRCNT_EN is defined, the block SHALL add an output err_spurious (1 bit, sticky) and an output err_count (8 bits, saturating at 255). Both SHALL increment or set on each spurious event from REQ-019, and both SHALL clear only on reset.
REQ-023 When AES256_SCHED_ERRCNT_EN is not defined, those ports and registers SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-024 Key load:
- Stimulus: after reset, pulse key_valid with key_data = {128'h0f0e0d0c0b0a09080706050403020100, 128'h1f1e1d1c1b1a19181716151413121110}.
- Required response: two consecutive dev_ctrl_dataIn cycles with mod_en=10, low half 1f1e...10 first, then high half 0f0e...00; key_loaded=1 after the second cycle.
REQ-025 Grant before key:
- Stimulus: ch0_valid=1 before any key load.
- Required response: ch0_ready stays 0 and dev_ctrl_dataIn stays 0.
REQ-026 Arbitration:
- Stimulus: ch0 and ch1 both valid continuously, ch0_dec=0, ch1_dec=1, ch1_data=128'h7a584d99febc93ead6b3563cc4ad3a63.
- Required response: grants alternate ch0, ch1, ch0, ...; mod_en alternates 00, 01; grants stop after FIFO_DEPTH=4 outstanding.
REQ-027 Response ordering:
- Stimulus: model returns 4 dev_ctrl_dataOut pulses.
- Required response: rsp_ch sequence 0, 1, 0, 1; rsp_data equals dev_outp delayed one cycle; grants resume after the first pop.
REQ-028 Key during traffic:
- Stimulus: key_valid asserted with 3 operations outstanding.
- Required response: no key_ready until 3 responses have returned, then KEY_LO and KEY_HI issue.
REQ-029 Spurious output and reset:
- Stimulus: a dev_ctrl_dataOut pulse with the FIFO empty; then reset mid-KEY_LO.
- Required response: no rsp_valid; err_count=1 when AES256_SCHED_ERRCNT_EN is defined; after the reset, key_loaded=0 and all outputs are 0.
